// File: rtl/hbm_rd_data_demux_pkg.sv
// ---------------------------------------------------------------------------
// hbm_rd_data_demux_pkg : shared tags, response codes and error-bit indices
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hbm_rd_data_demux_pkg;

  // Tag values must match the ones the HBM read-address generator issues
  localparam logic [5:0] MEM_RD_A_TAG = 6'h01;
  localparam logic [5:0] MEM_RD_B_TAG = 6'h02;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  localparam int ERR_RRESP = 0;
  localparam int ERR_RID   = 1;
  localparam int ERR_BLEN  = 2;
  localparam int ERR_LATE  = 3;

  typedef enum logic [1:0] {
    TAG_A     = 2'd0,
    TAG_B     = 2'd1,
    TAG_OTHER = 2'd2
  } rd_tag_e;

endpackage

`default_nettype wire

// File: rtl/hbm_rd_data_demux_if.sv
// ---------------------------------------------------------------------------
// hbm_rd_data_demux_if : AXI R channel plus the a/b output streams
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hbm_rd_data_demux_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6
) ();

  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;
  logic [DATA_WIDTH-1:0] m_axi_RDATA;
  logic [ID_WIDTH-1:0]   m_axi_RID;
  logic                  m_axi_RLAST;
  logic [1:0]            m_axi_RRESP;

  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_last;

  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_last;

  // Demux view: R-channel sink, stream source
  modport slave (
    input  m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RLAST, m_axi_RRESP,
    output m_axi_RREADY,
    output b_valid, b_data, b_last,
    input  b_ready,
    output a_valid, a_data, a_last,
    input  a_ready
  );

  modport master (
    output m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RLAST, m_axi_RRESP,
    input  m_axi_RREADY,
    input  b_valid, b_data, b_last,
    output b_ready,
    input  a_valid, a_data, a_last,
    output a_ready
  );

endinterface

`default_nettype wire

// File: rtl/hbm_rd_data_demux_fifo.sv
// ---------------------------------------------------------------------------
// hbm_rd_fifo : synchronous FIFO, write visible at the output one cycle later
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hbm_rd_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered count, so a same-cycle pop frees nothing
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;
  assign dout     = mem_q[rd_ptr_q];
  assign w_push   = wr_en && !full;
  assign w_pop    = rd_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/hbm_rd_data_demux.sv
// ---------------------------------------------------------------------------
// hbm_rd_data_demux : steers HBM R beats by RID into a/b stream FIFOs,
//                     checks framing/RRESP and signals run completion
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hbm_rd_data_demux
  import hbm_rd_data_demux_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 6,
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_BEATS = 4
) (
  input  logic                hbm_clk,
  input  logic                hbm_aresetn,
  input  logic                start,
  input  logic                hbm_read_done,
  input  logic [31:0]         rd_addr_cnt,
  hbm_rd_data_demux_if.slave  rd,
  output logic                rd_data_done,
  output logic [31:0]         bursts_rcvd,
  output logic [3:0]          err_flags
);

  localparam int              CW       = $clog2(BURST_BEATS) + 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(BURST_BEATS - 1);

  rd_tag_e             w_tag;
  logic                w_rready;
  logic                w_acc;
  logic                w_a_full, w_a_empty, w_a_valid;
  logic                w_b_full, w_b_empty, w_b_valid;
  logic [DATA_WIDTH:0] w_a_dout, w_b_dout;
  logic [CW:0]         w_step_a, w_step_b;
  logic                w_arm;

  logic                rready_en_q;
  logic [CW-1:0]       cnt_a_q, cnt_a_d;
  logic [CW-1:0]       cnt_b_q, cnt_b_d;
  logic [31:0]         bursts_q, bursts_d;
  logic [3:0]          err_q, err_d;
  logic                armed_q, armed_d;
  logic                done_q, done_d;

  // Returns {length_error, next_count} for one accepted beat of a tag
  function automatic logic [CW:0] beat_step(input logic [CW-1:0] cnt, input logic last);
    logic          err;
    logic [CW-1:0] nxt;
    err = 1'b0;
    nxt = cnt + CW'(1);
    if (last || (cnt == LAST_IDX)) begin
      err = (cnt != LAST_IDX) || !last;
      nxt = '0;
    end
    return {err, nxt};
  endfunction

  always_comb begin
    w_tag = TAG_OTHER;
    if (rd.m_axi_RID == ID_WIDTH'(MEM_RD_B_TAG))      w_tag = TAG_B;
    else if (rd.m_axi_RID == ID_WIDTH'(MEM_RD_A_TAG)) w_tag = TAG_A;
  end

  // Unknown RIDs are always accepted so a stray beat cannot stall the port
  always_comb begin
    case (w_tag)
      TAG_A:   w_rready = rready_en_q && !w_a_full;
      TAG_B:   w_rready = rready_en_q && !w_b_full;
      default: w_rready = rready_en_q;
    endcase
  end

  assign rd.m_axi_RREADY = w_rready;
  assign w_acc           = rd.m_axi_RVALID && w_rready;

  hbm_rd_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk      (hbm_clk),
    .rst_n    (hbm_aresetn),
    .wr_en    (w_acc && (w_tag == TAG_A)),
    .din      ({rd.m_axi_RLAST, rd.m_axi_RDATA}),
    .full     (w_a_full),
    .rd_valid (w_a_valid),
    .rd_ready (rd.a_ready),
    .dout     (w_a_dout),
    .empty    (w_a_empty)
  );

  hbm_rd_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk      (hbm_clk),
    .rst_n    (hbm_aresetn),
    .wr_en    (w_acc && (w_tag == TAG_B)),
    .din      ({rd.m_axi_RLAST, rd.m_axi_RDATA}),
    .full     (w_b_full),
    .rd_valid (w_b_valid),
    .rd_ready (rd.b_ready),
    .dout     (w_b_dout),
    .empty    (w_b_empty)
  );

  assign rd.a_valid = w_a_valid;
  assign rd.a_data  = w_a_dout[DATA_WIDTH-1:0];
  assign rd.a_last  = w_a_valid && w_a_dout[DATA_WIDTH];
  assign rd.b_valid = w_b_valid;
  assign rd.b_data  = w_b_dout[DATA_WIDTH-1:0];
  assign rd.b_last  = w_b_valid && w_b_dout[DATA_WIDTH];

  assign w_step_a = beat_step(cnt_a_q, rd.m_axi_RLAST);
  assign w_step_b = beat_step(cnt_b_q, rd.m_axi_RLAST);
  assign w_arm    = hbm_read_done && (bursts_q == rd_addr_cnt) &&
                    w_a_empty && w_b_empty && !armed_q;

  always_comb begin
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    bursts_d = bursts_q;
    err_d    = err_q;
    armed_d  = armed_q;
    done_d   = 1'b0;
    if (start) begin
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      bursts_d = '0;
      err_d    = '0;
      armed_d  = 1'b0;
    end else begin
      done_d  = w_arm;
      armed_d = armed_q || w_arm;
      if (w_acc) begin
        if (rd.m_axi_RRESP != RRESP_OKAY) err_d[ERR_RRESP] = 1'b1;
        if (rd.m_axi_RLAST)               bursts_d = bursts_q + 32'd1;
        if (armed_q)                      err_d[ERR_LATE] = 1'b1;
        case (w_tag)
          TAG_A: begin
            cnt_a_d = w_step_a[CW-1:0];
            if (w_step_a[CW]) err_d[ERR_BLEN] = 1'b1;
          end
          TAG_B: begin
            cnt_b_d = w_step_b[CW-1:0];
            if (w_step_b[CW]) err_d[ERR_BLEN] = 1'b1;
          end
          default: err_d[ERR_RID] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge hbm_clk) begin
    if (!hbm_aresetn) begin
      rready_en_q <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      bursts_q    <= '0;
      err_q       <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rready_en_q <= 1'b1;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      bursts_q    <= bursts_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end

  assign rd_data_done = done_q;
  assign bursts_rcvd  = bursts_q;
  assign err_flags    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hbm_rd_data_demux.sv
// ---------------------------------------------------------------------------
// tb_hbm_rd_data_demux : queue-based reference model, vector table,
//                        directed corner sequences and random traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hbm_rd_data_demux;
  import hbm_rd_data_demux_pkg::*;

  localparam int DW    = 256;
  localparam int IW    = 6;
  localparam int DEPTH = 64;
  localparam int BB    = 4;
  localparam logic [IW-1:0] TA = MEM_RD_A_TAG;
  localparam logic [IW-1:0] TB = MEM_RD_B_TAG;
  localparam logic [IW-1:0] TX = 6'h3F;

  logic        clk = 1'b0;
  logic        aresetn, start, read_done;
  logic [31:0] addr_cnt;
  logic        done;
  logic [31:0] bursts;
  logic [3:0]  err;

  always #5 clk = ~clk;

  hbm_rd_data_demux_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  hbm_rd_data_demux #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH), .BURST_BEATS(BB)
  ) dut (
    .hbm_clk       (clk),
    .hbm_aresetn   (aresetn),
    .start         (start),
    .hbm_read_done (read_done),
    .rd_addr_cnt   (addr_cnt),
    .rd            (bus),
    .rd_data_done  (done),
    .bursts_rcvd   (bursts),
    .err_flags     (err)
  );

  // Reference model: stream contents as queues, counters as plain ints
  typedef logic [DW:0] ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  int          cnt_a, cnt_b;
  logic [31:0] m_bursts;
  logic [3:0]  m_err;
  bit          m_armed, m_done, m_en, m_acc;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [IW-1:0] id;
    bit            last;
    logic [1:0]    resp;
    bit            exp_rready;
    logic [3:0]    exp_err;
    logic [31:0]   exp_bursts;
    bit            exp_av;
    bit            exp_bv;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    cnt_a = 0; cnt_b = 0; m_bursts = '0; m_err = '0; m_armed = 0; m_done = 0;
  endtask

  // One beat of a tagged burst; length errors per the burst framing rule
  task automatic beat_count(inout int c, input bit last);
    if (last) begin
      if (c != BB - 1) m_err[ERR_BLEN] = 1'b1;
      c = 0;
    end else if (c == BB - 1) begin
      m_err[ERR_BLEN] = 1'b1;
      c = 0;
    end else begin
      c++;
    end
  endtask

  // Check all outputs against the model at the negedge, then advance the model over the edge
  task automatic cycle();
    bit   rr, pa, pb, arm;
    ent_t e;
    @(negedge clk);
    if (!m_en)                     rr = 1'b0;
    else if (bus.m_axi_RID == TB)  rr = (qb.size() < DEPTH);
    else if (bus.m_axi_RID == TA)  rr = (qa.size() < DEPTH);
    else                           rr = 1'b1;
    chk("rready", bus.m_axi_RREADY, rr);
    chk("b_valid", bus.b_valid, qb.size() != 0);
    chk("a_valid", bus.a_valid, qa.size() != 0);
    if (qb.size() != 0) begin
      chk("b_data", bus.b_data, qb[0][DW-1:0]);
      chk("b_last", bus.b_last, qb[0][DW]);
    end else chk("b_last_idle", bus.b_last, 1'b0);
    if (qa.size() != 0) begin
      chk("a_data", bus.a_data, qa[0][DW-1:0]);
      chk("a_last", bus.a_last, qa[0][DW]);
    end else chk("a_last_idle", bus.a_last, 1'b0);
    chk("done", done, m_done);
    chk("bursts", bursts, m_bursts);
    chk("err", err, m_err);

    m_acc = bus.m_axi_RVALID && rr;
    pa    = (qa.size() != 0) && bus.a_ready;
    pb    = (qb.size() != 0) && bus.b_ready;
    arm   = read_done && (m_bursts == addr_cnt) && (qa.size() == 0) &&
            (qb.size() == 0) && !m_armed;
    if (!aresetn) begin
      qa.delete(); qb.delete(); model_clear(); m_en = 0;
    end else begin
      m_en = 1;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      e = {bus.m_axi_RLAST, bus.m_axi_RDATA};
      if (m_acc && bus.m_axi_RID == TA) qa.push_back(e);
      if (m_acc && bus.m_axi_RID == TB) qb.push_back(e);
      if (start) begin
        model_clear();
      end else begin
        if (m_acc) begin
          if (bus.m_axi_RRESP != 2'b00) m_err[ERR_RRESP] = 1'b1;
          if (bus.m_axi_RLAST)          m_bursts = m_bursts + 32'd1;
          if (m_armed)                  m_err[ERR_LATE] = 1'b1;
          if (bus.m_axi_RID == TA)      beat_count(cnt_a, bus.m_axi_RLAST);
          else if (bus.m_axi_RID == TB) beat_count(cnt_b, bus.m_axi_RLAST);
          else                          m_err[ERR_RID] = 1'b1;
        end
        m_done = arm;
        if (arm) m_armed = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] id, input logic [DW-1:0] d,
                      input bit last, input logic [1:0] resp);
    int n = 0;
    bus.m_axi_RVALID = 1'b1; bus.m_axi_RID = id; bus.m_axi_RDATA = d;
    bus.m_axi_RLAST  = last; bus.m_axi_RRESP = resp;
    do begin cycle(); n++; end while (!m_acc && n < 300);
    if (!m_acc) chk("send_timeout", m_acc, 1'b1);
    bus.m_axi_RVALID = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.m_axi_RVALID = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_burst(input logic [IW-1:0] id, input int base);
    for (int k = 0; k < BB; k++) send(id, DW'(base + k), k == BB - 1, 2'b00);
  endtask

  initial begin
    int npulse;
    logic [DW-1:0] rd_d;
    int p_ready;

    tbl[0] = '{TB, 1'b0, 2'b00, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1};
    tbl[1] = '{TA, 1'b0, 2'b00, 1'b1, 4'b0000, 32'd0, 1'b1, 1'b0};
    tbl[2] = '{TA, 1'b1, 2'b00, 1'b1, 4'b0100, 32'd1, 1'b1, 1'b0};
    tbl[3] = '{TB, 1'b0, 2'b10, 1'b1, 4'b0001, 32'd0, 1'b0, 1'b1};
    tbl[4] = '{TX, 1'b0, 2'b00, 1'b1, 4'b0010, 32'd0, 1'b0, 1'b0};
    tbl[5] = '{TX, 1'b1, 2'b11, 1'b1, 4'b0011, 32'd1, 1'b0, 1'b0};

    aresetn = 1'b0; start = 1'b0; read_done = 1'b0; addr_cnt = '0;
    bus.m_axi_RVALID = 1'b0; bus.m_axi_RID = TB; bus.m_axi_RDATA = '0;
    bus.m_axi_RLAST = 1'b0; bus.m_axi_RRESP = 2'b00;
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    qa.delete(); qb.delete(); model_clear(); m_en = 0; m_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    bus.m_axi_RVALID = 1'b1;
    #1;
    chk("rst_rready", bus.m_axi_RREADY, 1'b0);
    chk("rst_bvalid", bus.b_valid, 1'b0);
    chk("rst_avalid", bus.a_valid, 1'b0);
    chk("rst_bursts", bursts, 32'd0);
    chk("rst_err", err, 4'd0);
    chk("rst_done", done, 1'b0);
    bus.m_axi_RVALID = 1'b0;
    idle(1);

    // Single B burst
    pulse_start();
    send_burst(TB, 0);
    idle(2);
    chk("t1_bursts", bursts, 32'd1);
    chk("t1_err", err, 4'd0);

    // Beat-by-beat interleave of A and B
    pulse_start();
    for (int i = 0; i < 16; i++)
      send((i % 2) ? TB : TA, DW'(32'h100 + i), ((i / 2) % BB) == BB - 1, 2'b00);
    idle(2);
    chk("t2_bursts", bursts, 32'd4);
    chk("t2_err", err, 4'd0);

    // Fill the A FIFO, confirm back-pressure is per tag
    pulse_start();
    bus.a_ready = 1'b0;
    for (int i = 0; i < 16 * BB; i++) send(TA, DW'(32'h200 + i), (i % BB) == BB - 1, 2'b00);
    bus.m_axi_RVALID = 1'b1; bus.m_axi_RID = TA; bus.m_axi_RDATA = DW'(32'h240);
    bus.m_axi_RLAST = 1'b0; bus.m_axi_RRESP = 2'b00;
    #1;
    chk("t3_full_rready", bus.m_axi_RREADY, 1'b0);
    bus.m_axi_RID = TB;
    #1;
    chk("t3_b_rready", bus.m_axi_RREADY, 1'b1);
    send(TB, DW'(32'h2B0), 1'b0, 2'b00);
    cycle();
    chk("t3_a_still_full", qa.size(), DEPTH);
    bus.a_ready = 1'b1;
    for (int k = 0; k < BB; k++) send(TA, DW'(32'h240 + k), k == BB - 1, 2'b00);
    idle(DEPTH + 8);
    chk("t3_bursts", bursts, 32'd17);
    chk("t3_drained", bus.a_valid, 1'b0);

    // Framing, RRESP and unknown-RID errors
    pulse_start();
    for (int k = 0; k < 3; k++) send(TA, DW'(k), k == 2, 2'b00);
    chk("t4_short", err, 4'b0100);
    for (int k = 0; k < BB; k++) send(TB, DW'(k), 1'b0, 2'b00);
    send_burst(TA, 32'h300);
    chk("t4_sticky", err, 4'b0100);
    send(TB, DW'(32'h55), 1'b0, 2'b10);
    chk("t4_rresp", err, 4'b0101);
    bus.m_axi_RVALID = 1'b1; bus.m_axi_RID = TX;
    #1;
    chk("t4_unk_rready", bus.m_axi_RREADY, 1'b1);
    send(TX, DW'(32'h66), 1'b0, 2'b00);
    chk("t4_unk", err, 4'b0111);
    chk("t4_bursts", bursts, 32'd2);
    idle(3);

    // Vector table: one beat after a fresh start, both streams held
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_start();
      bus.m_axi_RVALID = 1'b1; bus.m_axi_RID = tbl[i].id; bus.m_axi_RDATA = DW'(i);
      bus.m_axi_RLAST = tbl[i].last; bus.m_axi_RRESP = tbl[i].resp;
      #1;
      chk("tbl_rready", bus.m_axi_RREADY, tbl[i].exp_rready);
      cycle();
      bus.m_axi_RVALID = 1'b0;
      chk("tbl_err", err, tbl[i].exp_err);
      chk("tbl_bursts", bursts, tbl[i].exp_bursts);
      chk("tbl_avalid", bus.a_valid, tbl[i].exp_av);
      chk("tbl_bvalid", bus.b_valid, tbl[i].exp_bv);
      bus.a_ready = 1'b1; bus.b_ready = 1'b1;
      cycle();
      bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    end
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    idle(2);

    // Completion: 8 bursts, single done pulse, late beat, start clears
    pulse_start();
    addr_cnt = 32'd8; read_done = 1'b1;
    for (int b = 0; b < 8; b++) send_burst((b % 2) ? TB : TA, 32'h400 + b * 16);
    chk("t5_bursts", bursts, 32'd8);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (done) npulse++;
    end
    chk("t5_done_pulses", npulse, 1);
    send(TA, DW'(32'h4FF), 1'b0, 2'b00);
    chk("t5_late", err, 4'b1000);
    pulse_start();
    chk("t5_start_err", err, 4'd0);
    chk("t5_start_bursts", bursts, 32'd0);
    read_done = 1'b0; addr_cnt = '0;
    idle(3);

    // Reset with both FIFOs holding data
    pulse_start();
    bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    send(TA, DW'(1), 1'b0, 2'b00); send(TB, DW'(2), 1'b0, 2'b00);
    send(TA, DW'(3), 1'b0, 2'b00); send(TB, DW'(4), 1'b1, 2'b00);
    aresetn = 1'b0;
    bus.m_axi_RVALID = 1'b1; bus.m_axi_RID = TB;
    cycle();
    chk("t6_avalid", bus.a_valid, 1'b0);
    chk("t6_bvalid", bus.b_valid, 1'b0);
    chk("t6_rready", bus.m_axi_RREADY, 1'b0);
    chk("t6_bursts", bursts, 32'd0);
    aresetn = 1'b1; bus.m_axi_RVALID = 1'b0;
    cycle();
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    send_burst(TB, 32'h600);
    idle(2);
    chk("t6_after", bursts, 32'd1);

    // Random traffic, ready probability varies per block to exercise full FIFOs
    pulse_start();
    for (int blk = 0; blk < 6; blk++) begin
      p_ready = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 500; c++) begin
        for (int k = 0; k < DW / 32; k++) rd_d[k*32 +: 32] = $urandom;
        bus.m_axi_RVALID = ($urandom_range(99) < 70);
        case ($urandom_range(19))
          0, 1:    bus.m_axi_RID = TX;
          default: bus.m_axi_RID = ($urandom_range(1) == 0) ? TA : TB;
        endcase
        bus.m_axi_RDATA = rd_d;
        bus.m_axi_RLAST = ($urandom_range(3) == 0);
        bus.m_axi_RRESP = ($urandom_range(19) == 0) ? 2'b10 : 2'b00;
        bus.a_ready     = ($urandom_range(99) < p_ready);
        bus.b_ready     = ($urandom_range(99) < p_ready);
        start           = ($urandom_range(299) == 0);
        cycle();
      end
    end
    start = 1'b0;
    bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    idle(DEPTH + 4);
    chk("rand_drained_a", bus.a_valid, 1'b0);
    chk("rand_drained_b", bus.b_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
